store_align_buf: RTL and testbench
==================================

Name: store_align_buf

Overview:
- Store-side counterpart of the load extender in the MIPS data-memory path.
- Accepts sw/sh/sb requests from the MEM stage and positions byte/halfword data into the correct word lanes.
- Generates per-byte write enables and queues the results in a small FIFO.
- Drains the FIFO to data memory over a valid/ready handshake, so the pipeline stalls only when the buffer is full.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- PTR_W, 2: log2(DEPTH); pointer width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- st_valid  in  1  store request present.
- st_ready  out  1  buffer can accept the request this cycle.
- st_op  in  2  00=sw, 01=sb, 10=sh, 11=reserved.
- st_addr  in  32  byte address.
- st_data  in  32  rt register value; low byte/half used for sb/sh.
- mem_valid  out  1  head entry valid.
- mem_ready  in  1  memory accepts head entry.
- mem_addr  out  32  word address, {st_addr[31:2],2'b00}.
- mem_be  out  4  byte enables, bit i = byte lane i (Din[8i+7:8i]).
- mem_wdata  out  32  lane-aligned write data.
- buf_empty  out  1  no entries held.
- buf_count  out  PTR_W+1  occupancy, 0..DEPTH.

Behaviour:
- Reset: clears pointers and count. After reset: buf_empty=1, buf_count=0, mem_valid=0, st_ready=1. mem_addr, mem_be and mem_wdata read 0 while the buffer is empty.
- Push: occurs when st_valid && st_ready. The entry is computed combinationally from st_op, st_addr[1:0] and st_data.
  - sw: be=1111, wdata=st_data.
  - sb: be=1<<addr[1:0], wdata={4{st_data[7:0]}}.
  - sh, addr[1]=0: be=0011, wdata={2{st_data[15:0]}}.
  - sh, addr[1]=1: be=1100, wdata={2{st_data[15:0]}}.
  - Replicated data is intentional; memory uses mem_be only.
- Misaligned or reserved requests are handled per the Optional Feature section. The default is to mask the address bits.
- Reserved op (11): consumed (st_ready honoured) but no entry is pushed.
- Pop: occurs when mem_valid && mem_ready. mem_* outputs come straight from the head entry. No data is ever lost or duplicated.
- Latency: an accepted store is visible on mem_* at the earliest in the next cycle. There is no combinational path from st_* to mem_*.
- Full: st_ready=0 when buf_count==DEPTH, even if a pop happens in the same cycle. This keeps st_ready free of any combinational dependence on mem_ready.
- Empty: mem_valid=0. A push into an empty buffer raises mem_valid on the next edge.
- Simultaneous push and pop (not full, not empty): buf_count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. buf_count distinguishes full from empty.
- Ordering: strict FIFO; memory sees writes in program order.
- reset asserted mid-drain: all pending entries are discarded, mem_valid=0 the next cycle, and no further pops occur.
- mem_* outputs remain stable while mem_valid && !mem_ready.

Optional Feature:
- Macro: STORE_ALIGN_EXC_EN.
- Defined:
  - Adds output st_adel (1-bit, registered, reset 0).
  - Condition: sh with addr[0]=1, or sw with addr[1:0]!=00, while st_valid && st_ready.
  - Effect: the store is not pushed, and st_adel pulses high for exactly one cycle after acceptance.
- Undefined:
  - No st_adel port.
  - Low address bits are masked: sw uses addr[1:0]=00, sh uses addr[0]=0.
  - The store is always pushed.

Decomposition:
- Package store_pkg holds:
  - ST_OP_SW/SB/SH/RSV opcodes (2-bit).
  - Byte-enable constants BE_WORD=4'b1111, BE_LO=4'b0011, BE_HI=4'b1100.
  - The entry struct {addr[31:2], be[3:0], wdata[31:0]}.
- One sub-module: store_lane_gen, purely combinational. It maps op/addr/data to be/wdata/misalign.
- FIFO storage, pointers and handshake stay in store_align_buf.

Test Plan:
- Lane placement: sb to 0x1003 with data 0x000000A5, mem_ready=1 → next cycle mem_valid=1, mem_addr=0x1000, mem_be=1000, mem_wdata=0xA5A5A5A5. sh to 0x2002 with 0x1234BEEF → be=1100, wdata=0xBEEFBEEF. sw to 0x3000 with 0xDEADBEEF → be=1111, wdata=0xDEADBEEF.
- Fill and drain: mem_ready=0, push 4 sw (addrs 0x0,0x4,0x8,0xC) → buf_count=4, st_ready=0, 5th request held. Then mem_ready=1 → pops in order 0x0,0x4,0x8,0xC, buf_empty=1 after the 4th pop.
- Simultaneous push/pop at count=2 for 10 cycles → buf_count stays 2, output order matches input order, pointers wrap correctly.
- Reset mid-drain: count=3, assert reset for 1 cycle → buf_count=0, mem_valid=0, st_ready=1. The following sb to 0x5 yields be=0010, addr=0x4.
- Reserved op 11 at st_addr 0x10 → st_ready=1, buf_count unchanged, mem_valid stays 0.
- With STORE_ALIGN_EXC_EN: sh to 0x101 → st_adel=1 for one cycle, no push. Without the macro, the same request → be=0011, addr=0x100.

Source files
------------

// File: rtl/store_pkg.sv
// Shared opcodes, byte-enable patterns and the buffered store entry format
// for the store alignment buffer.
package store_pkg;

   localparam logic [1:0] ST_OP_SW  = 2'b00;
   localparam logic [1:0] ST_OP_SB  = 2'b01;
   localparam logic [1:0] ST_OP_SH  = 2'b10;
   localparam logic [1:0] ST_OP_RSV = 2'b11;

   localparam logic [3:0] BE_WORD = 4'b1111;
   localparam logic [3:0] BE_LO   = 4'b0011;
   localparam logic [3:0] BE_HI   = 4'b1100;

   // One queued memory write: word address, lane enables, lane-aligned data
   typedef struct packed {
      logic [29:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } st_entry_t;

endpackage

// File: rtl/store_lane_gen.sv
// Combinational lane placement: turns a store op, the low address bits and
// the rt value into byte enables and replicated write data. Also flags
// misaligned sw/sh so the top level can either ignore it (low bits masked)
// or raise an address-error exception.
module store_lane_gen
   import store_pkg::*;
(
   input  logic [1:0]  op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] data,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic        misalign
);

   logic [3:0] sb_be;

   // One-hot byte lane select for sb, one comparator per lane
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sb_lane
         assign sb_be[gi] = (addr_lo == 2'(gi));
      end
   endgenerate

   // Decode op into enables/data; halfword lane uses addr[1] only, so addr[0] is masked
   always_comb begin
      be       = 4'b0000;
      wdata    = 32'h0;
      misalign = 1'b0;
      case (op)
         ST_OP_SW: begin
            be       = BE_WORD;
            wdata    = data;
            misalign = (addr_lo != 2'b00);
         end
         ST_OP_SB: begin
            be    = sb_be;
            wdata = {4{data[7:0]}};
         end
         ST_OP_SH: begin
            be       = addr_lo[1] ? BE_HI : BE_LO;
            wdata    = {2{data[15:0]}};
            misalign = addr_lo[0];
         end
         default: begin
            be       = 4'b0000;
            wdata    = 32'h0;
            misalign = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/store_align_buf.sv
// Store alignment buffer: lane-aligns sw/sh/sb requests and queues them in
// a small FIFO that drains to data memory over valid/ready.
// Optional build macro STORE_ALIGN_EXC_EN: misaligned sw/sh are dropped and
// reported on the registered st_adel pulse instead of being masked.
module store_align_buf
   import store_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [1:0]        st_op,
   input  logic [31:0]       st_addr,
   input  logic [31:0]       st_data,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [31:0]       mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   output logic              buf_empty,
   output logic [PTR_W:0]    buf_count
`ifdef STORE_ALIGN_EXC_EN
   ,
   output logic              st_adel
`endif
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   st_entry_t          fifo_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     count_q, count_d;

   logic               push_acc;
   logic               push_en;
   logic               pop_en;
   logic [3:0]         lane_be;
   logic [31:0]        lane_wdata;
   logic               lane_misalign;
   st_entry_t          new_entry;
   st_entry_t          head_entry;

   store_lane_gen u_lane_gen (
      .op       (st_op),
      .addr_lo  (st_addr[1:0]),
      .data     (st_data),
      .be       (lane_be),
      .wdata    (lane_wdata),
      .misalign (lane_misalign)
   );

   // st_ready depends only on registered occupancy, never on mem_ready
   assign st_ready  = (count_q != FULL_CNT);
   assign mem_valid = (count_q != '0);
   assign push_acc  = st_valid && st_ready;
   assign pop_en    = mem_valid && mem_ready;

`ifdef STORE_ALIGN_EXC_EN
   logic adel_q, adel_d;

   assign push_en = push_acc && (st_op != ST_OP_RSV) && !lane_misalign;
   assign adel_d  = push_acc && lane_misalign;
   assign st_adel = adel_q;

   // Address-error pulse, one cycle after the offending store is accepted
   always_ff @(posedge clk) begin
      if (reset) adel_q <= 1'b0;
      else       adel_q <= adel_d;
   end
`else
   logic unused_misalign;

   assign unused_misalign = lane_misalign;
   assign push_en         = push_acc && (st_op != ST_OP_RSV);
`endif

   // Assemble the entry to be written and read the head entry
   always_comb begin
      new_entry.addr  = st_addr[31:2];
      new_entry.be    = lane_be;
      new_entry.wdata = lane_wdata;
      head_entry      = fifo_q[rd_ptr_q];
   end

   // Memory-side outputs read zero while nothing is buffered
   always_comb begin
      mem_addr  = 32'h0;
      mem_be    = 4'b0000;
      mem_wdata = 32'h0;
      if (mem_valid) begin
         mem_addr  = {head_entry.addr, 2'b00};
         mem_be    = head_entry.be;
         mem_wdata = head_entry.wdata;
      end
   end

   assign buf_empty = !mem_valid;
   assign buf_count = count_q;

   // Next-state pointers and occupancy; pointers wrap naturally at DEPTH
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_en, pop_en})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers; reset discards all pending entries
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents need no reset because outputs are gated by occupancy
   always_ff @(posedge clk) begin
      if (push_en) fifo_q[wr_ptr_q] <= new_entry;
   end

endmodule

// File: tb/tb_store_align_buf.sv
// Testbench for store_align_buf: directed steps from the test plan followed
// by random traffic, all compared against a queue-based reference model.
module tb_store_align_buf;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              st_valid;
   logic              st_ready;
   logic [1:0]        st_op;
   logic [31:0]       st_addr;
   logic [31:0]       st_data;
   logic              mem_valid;
   logic              mem_ready;
   logic [31:0]       mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic              buf_empty;
   logic [PTR_W:0]    buf_count;
`ifdef STORE_ALIGN_EXC_EN
   logic              st_adel;
`endif

   store_align_buf #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .st_valid  (st_valid),
      .st_ready  (st_ready),
      .st_op     (st_op),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .buf_empty (buf_empty),
      .buf_count (buf_count)
`ifdef STORE_ALIGN_EXC_EN
      ,
      .st_adel   (st_adel)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } exp_t;

   exp_t model_q[$];
   logic adel_exp;
   int   vectors;
   int   miscompares;

   // Reference byte enables computed from the lane rules with arithmetic
   function automatic logic [3:0] ref_be(input logic [1:0] op, input logic [31:0] a);
      int lane;
      lane = int'(a % 4);
      case (op)
         2'd0:    return 4'hF;
         2'd1:    return 4'(1 << lane);
         2'd2:    return (lane >= 2) ? 4'hC : 4'h3;
         default: return 4'h0;
      endcase
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [1:0] op, input logic [31:0] d);
      case (op)
         2'd1:    return (d % 256) * 32'h0101_0101;
         2'd2:    return (d % 65536) * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   function automatic bit ref_misaligned(input logic [1:0] op, input logic [31:0] a);
      return (op == 2'd0 && (a % 4) != 0) || (op == 2'd2 && (a % 2) != 0);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Compare every visible output against the model state
   task automatic check_outputs(input string where);
      bit nonempty;
      nonempty = (model_q.size() != 0);
      chk({where, ".st_ready"},  32'(st_ready),  32'(model_q.size() < DEPTH));
      chk({where, ".mem_valid"}, 32'(mem_valid), 32'(nonempty));
      chk({where, ".buf_empty"}, 32'(buf_empty), 32'(!nonempty));
      chk({where, ".buf_count"}, 32'(buf_count), 32'(model_q.size()));
      chk({where, ".mem_addr"},  mem_addr,       nonempty ? model_q[0].addr  : 32'h0);
      chk({where, ".mem_be"},    32'(mem_be),    nonempty ? 32'(model_q[0].be) : 32'h0);
      chk({where, ".mem_wdata"}, mem_wdata,      nonempty ? model_q[0].wdata : 32'h0);
`ifdef STORE_ALIGN_EXC_EN
      chk({where, ".st_adel"},   32'(st_adel),   32'(adel_exp));
`endif
   endtask

   // One clock: drive at negedge, check state, advance model across the posedge
   task automatic step(input string where, input logic v, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] d, input logic mr);
      bit accepted;
      bit do_push;
      exp_t e;
      st_valid  = v;
      st_op     = op;
      st_addr   = a;
      st_data   = d;
      mem_ready = mr;
      #1;
      check_outputs(where);
      accepted = v && (model_q.size() < DEPTH);
      do_push  = accepted && (op != 2'd3);
`ifdef STORE_ALIGN_EXC_EN
      adel_exp = accepted && ref_misaligned(op, a);
      if (ref_misaligned(op, a)) do_push = 1'b0;
`endif
      e.addr  = a - (a % 4);
      e.be    = ref_be(op, a);
      e.wdata = ref_wdata(op, d);
      if (model_q.size() != 0 && mr) void'(model_q.pop_front());
      if (do_push) model_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input logic mr);
      reset     = 1'b1;
      st_valid  = 1'b0;
      st_op     = 2'd0;
      st_addr   = 32'h0;
      st_data   = 32'h0;
      mem_ready = mr;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_q.delete();
      adel_exp = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      adel_exp    = 1'b0;
      @(negedge clk);
      do_reset(1'b0);
      do_reset(1'b0);
      check_outputs("reset");

      // Lane placement
      step("sb1003", 1, 2'd1, 32'h1003, 32'h0000_00A5, 1);
      step("sh2002", 1, 2'd2, 32'h2002, 32'h1234_BEEF, 1);
      step("sw3000", 1, 2'd0, 32'h3000, 32'hDEAD_BEEF, 1);
      step("lane_drain", 0, 2'd0, 32'h0, 32'h0, 1);

      // Fill, hold a fifth request, then drain in order
      for (int i = 0; i < 4; i++) step("fill", 1, 2'd0, 32'(i * 4), 32'h100 + 32'(i), 0);
      step("full_hold", 1, 2'd0, 32'h10, 32'h999, 0);
      for (int i = 0; i < 5; i++) step("drain", 0, 2'd0, 32'h0, 32'h0, 1);

      // Steady push+pop at occupancy 2, wrapping the pointers
      step("pp_pre", 1, 2'd0, 32'h40, 32'h40, 0);
      step("pp_pre", 1, 2'd0, 32'h44, 32'h44, 0);
      for (int i = 0; i < 10; i++) step("pp", 1, 2'd1, 32'h48 + 32'(i), 32'(i * 17), 1);
      for (int i = 0; i < 3; i++) step("pp_drain", 0, 2'd0, 32'h0, 32'h0, 1);

      // Reset while draining
      for (int i = 0; i < 3; i++) step("pre_rst", 1, 2'd0, 32'h80 + 32'(i * 4), 32'(i), 0);
      do_reset(1'b1);
      check_outputs("mid_rst");
      step("sb5", 1, 2'd1, 32'h5, 32'h0000_0077, 0);
      step("sb5_chk", 0, 2'd0, 32'h0, 32'h0, 1);

      // Reserved op is consumed without an entry
      step("rsv", 1, 2'd3, 32'h10, 32'h1234, 0);
      step("rsv_chk", 0, 2'd0, 32'h0, 32'h0, 1);

      // Misaligned halfword: masked, or trapped when the exception build is on
      step("sh101", 1, 2'd2, 32'h101, 32'hCAFE_F00D, 0);
      step("sh101_chk", 0, 2'd0, 32'h0, 32'h0, 1);
      step("sh101_idle", 0, 2'd0, 32'h0, 32'h0, 1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step("rand", ($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
              $urandom, $urandom, ($urandom_range(0, 1) == 1));
      end
      for (int i = 0; i < DEPTH + 1; i++) step("final_drain", 0, 2'd0, 32'h0, 32'h0, 1);
      check_outputs("end");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
